// File: rtl/bash_hash_bus_master.sv
// bash_hash_bus_master: register-bus initiator that runs one bash_hash job
// end to end (L, PREP, 32 X words, START, RDY poll, 16 Y words).
// Optional poll timeout with sticky err_o: define BASH_MASTER_TIMEOUT_EN.
// The register map is shared with the core through bash_hash_params_pkg.

package bash_hash_params_pkg;
    localparam int         BASH_XLEN       = 32;
    localparam logic [7:0] X_BASE          = 8'h00;
    localparam logic [7:0] Y_BASE          = 8'h80;
    localparam logic [7:0] L_ADDR          = 8'hC0;
    localparam logic [7:0] PREP_ADDR       = 8'hC4;
    localparam logic [7:0] START_ADDR      = 8'hC8;
    localparam logic [7:0] RDY_ACTIVE_ADDR = 8'hCC;
endpackage

module bash_hash_bus_master
    import bash_hash_params_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int ADDRLEN     = 8,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               go_i,
    input  logic [XLEN-1:0]    l_i,
    input  logic [XLEN-1:0]    x_data_i,
    input  logic               x_valid_i,
    output logic               x_ready_o,
    output logic [XLEN-1:0]    y_data_o,
    output logic               y_valid_o,
    input  logic               y_ready_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic               en_o,
    output logic [3:0]         we_o,
    output logic [ADDRLEN-1:0] addr_o,
    output logic [XLEN-1:0]    wrdata_o,
    input  logic [XLEN-1:0]    rddata_i
);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_L, S_PREP, S_WR_X, S_START, S_POLL, S_RD_Y, S_DONE
    } state_t;

    state_t             state_reg, state_next;
    logic [5:0]         xcnt_reg, xcnt_next;
    logic [4:0]         ycnt_reg, ycnt_next;
    logic [4:0]         ycnt_inc;
    // Bus outputs are registered: the *_next values describe the access
    // that happens in the cycle after the current edge.
    logic               en_reg, en_next;
    logic [3:0]         we_reg, we_next;
    logic [ADDRLEN-1:0] addr_reg, addr_next;
    logic [XLEN-1:0]    wrdata_reg, wrdata_next;
    logic [XLEN-1:0]    y_data_reg, y_data_next;
    logic               y_valid_reg, y_valid_next;
    logic               done_reg, done_next;
    logic               x_ready;

`ifdef BASH_MASTER_TIMEOUT_EN
    logic [31:0]        poll_cnt_reg, poll_cnt_next;
    logic               err_reg, err_next;
    assign err_o = err_reg;
`else
    logic               unused_cfg;
    assign unused_cfg = (TIMEOUT_CYC == 0);
    assign err_o = 1'b0;
`endif

    // A write in flight (en_reg) blocks the next X word: 1 word per 2 cycles.
    assign x_ready   = (state_reg == S_WR_X) && (xcnt_reg < 6'd32) && !en_reg;
    assign ycnt_inc  = ycnt_reg + 5'd1;

    assign x_ready_o = x_ready;
    assign y_data_o  = y_data_reg;
    assign y_valid_o = y_valid_reg;
    assign busy_o    = (state_reg != S_IDLE);
    assign done_o    = done_reg;
    assign en_o      = en_reg;
    assign we_o      = we_reg;
    assign addr_o    = addr_reg;
    assign wrdata_o  = wrdata_reg;

    // Next-state, counter and next-bus-access decode.
    always_comb begin
        state_next   = state_reg;
        xcnt_next    = xcnt_reg;
        ycnt_next    = ycnt_reg;
        en_next      = 1'b0;
        we_next      = 4'h0;
        addr_next    = '0;
        wrdata_next  = '0;
        y_data_next  = y_data_reg;
        y_valid_next = y_valid_reg;
        done_next    = 1'b0;
`ifdef BASH_MASTER_TIMEOUT_EN
        poll_cnt_next = poll_cnt_reg;
        err_next      = err_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                if (go_i) begin
                    // The L write data register doubles as the latch of l_i.
                    state_next  = S_WR_L;
                    en_next     = 1'b1;
                    we_next     = 4'hF;
                    addr_next   = ADDRLEN'(L_ADDR);
                    wrdata_next = l_i;
`ifdef BASH_MASTER_TIMEOUT_EN
                    err_next    = 1'b0;
`endif
                end
            end
            S_WR_L: begin
                state_next = S_PREP;
                en_next    = 1'b1;
                we_next    = 4'hF;
                addr_next  = ADDRLEN'(PREP_ADDR);
            end
            S_PREP: begin
                state_next = S_WR_X;
                xcnt_next  = 6'd0;
            end
            S_WR_X: begin
                if (en_reg) begin
                    xcnt_next = xcnt_reg + 6'd1;
                    if (xcnt_reg == 6'd31) begin
                        state_next = S_START;
                        en_next    = 1'b1;
                        we_next    = 4'hF;
                        addr_next  = ADDRLEN'(START_ADDR);
                    end
                end else if (x_ready && x_valid_i) begin
                    en_next     = 1'b1;
                    we_next     = 4'hF;
                    addr_next   = ADDRLEN'(X_BASE) + ADDRLEN'({xcnt_reg, 2'b00});
                    wrdata_next = x_data_i;
                end
            end
            S_START: begin
                state_next = S_POLL;
                en_next    = 1'b1;
                addr_next  = ADDRLEN'(RDY_ACTIVE_ADDR);
`ifdef BASH_MASTER_TIMEOUT_EN
                poll_cnt_next = 32'd0;
`endif
            end
            S_POLL: begin
                // A poll read is on the bus in every POLL cycle.
`ifdef BASH_MASTER_TIMEOUT_EN
                poll_cnt_next = poll_cnt_reg + 32'd1;
`endif
                if (rddata_i[0]) begin
                    state_next = S_RD_Y;
                    ycnt_next  = 5'd0;
                    en_next    = 1'b1;
                    addr_next  = ADDRLEN'(Y_BASE);
`ifdef BASH_MASTER_TIMEOUT_EN
                end else if ((poll_cnt_reg + 32'd1) >= 32'(TIMEOUT_CYC)) begin
                    state_next = S_IDLE;
                    err_next   = 1'b1;
`endif
                end else begin
                    en_next   = 1'b1;
                    addr_next = ADDRLEN'(RDY_ACTIVE_ADDR);
                end
            end
            S_RD_Y: begin
                if (en_reg) begin
                    y_data_next  = rddata_i;
                    y_valid_next = 1'b1;
                end else if (y_valid_reg && y_ready_i) begin
                    y_valid_next = 1'b0;
                    ycnt_next    = ycnt_inc;
                    if (ycnt_reg == 5'd15) begin
                        state_next = S_DONE;
                        done_next  = 1'b1;
                    end else begin
                        en_next   = 1'b1;
                        addr_next = ADDRLEN'(Y_BASE) + ADDRLEN'({ycnt_inc, 2'b00});
                    end
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; reset drops everything to idle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg   <= S_IDLE;
            xcnt_reg    <= 6'd0;
            ycnt_reg    <= 5'd0;
            en_reg      <= 1'b0;
            we_reg      <= 4'h0;
            addr_reg    <= '0;
            wrdata_reg  <= '0;
            y_data_reg  <= '0;
            y_valid_reg <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            xcnt_reg    <= xcnt_next;
            ycnt_reg    <= ycnt_next;
            en_reg      <= en_next;
            we_reg      <= we_next;
            addr_reg    <= addr_next;
            wrdata_reg  <= wrdata_next;
            y_data_reg  <= y_data_next;
            y_valid_reg <= y_valid_next;
            done_reg    <= done_next;
        end
    end

`ifdef BASH_MASTER_TIMEOUT_EN
    // Poll counter and sticky timeout flag.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            poll_cnt_reg <= 32'd0;
            err_reg      <= 1'b0;
        end else begin
            poll_cnt_reg <= poll_cnt_next;
            err_reg      <= err_next;
        end
    end
`endif

endmodule

// File: tb/tb_bash_hash_bus_master.sv
// Scoreboard bench for bash_hash_bus_master: expected bus accesses and Y
// words are queued as each job is issued; monitors pop and compare.
`timescale 1ns/1ps
module tb_bash_hash_bus_master;
    import bash_hash_params_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        go_i = 1'b0;
    logic [31:0] l_i = '0;
    logic [31:0] x_data_i = '0;
    logic        x_valid_i = 1'b0;
    logic        x_ready_o;
    logic [31:0] y_data_o;
    logic        y_valid_o;
    logic        y_ready_i = 1'b1;
    logic        busy_o, done_o, err_o, en_o;
    logic [3:0]  we_o;
    logic [7:0]  addr_o;
    logic [31:0] wrdata_o;
    logic [31:0] rddata_i;

    typedef struct packed {
        logic [3:0]  we;
        logic [7:0]  addr;
        logic [31:0] data;
    } bus_t;

    bus_t        exp_bus_q[$];
    logic [31:0] exp_y_q[$];
    bus_t        mon_e;
    logic [31:0] mon_y;

    int checks = 0, errors = 0;
    int poll_seen = 0, poll_base = 0, rdy_after = 1;
    bit rdy_en = 1'b0;
    int done_cnt = 0, l_writes = 0;

    bash_hash_bus_master #(.XLEN(32), .ADDRLEN(8), .TIMEOUT_CYC(16)) dut (
        .clk_i(clk), .rst_i(rst_n), .go_i(go_i), .l_i(l_i),
        .x_data_i(x_data_i), .x_valid_i(x_valid_i), .x_ready_o(x_ready_o),
        .y_data_o(y_data_o), .y_valid_o(y_valid_o), .y_ready_i(y_ready_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .en_o(en_o), .we_o(we_o), .addr_o(addr_o), .wrdata_o(wrdata_o),
        .rddata_i(rddata_i)
    );

    always #5 clk = ~clk;

    // Slave model: RDY goes high on the rdy_after-th poll of the job; the Y
    // window returns a recognisable tag of the address.
    assign rddata_i = (addr_o == RDY_ACTIVE_ADDR) ?
                          {31'd0, rdy_en && ((poll_seen - poll_base) >= (rdy_after - 1))} :
                      (addr_o >= 8'h80 && addr_o <= 8'hBC) ? (32'hC0DE_0000 | {24'd0, addr_o}) :
                      32'd0;

    always @(posedge clk) begin
        if (rst_n && en_o && we_o == 4'h0 && addr_o == RDY_ACTIVE_ADDR)
            poll_seen <= poll_seen + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bus monitor: every access must match the next queued expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (en_o) begin
                $display("bus t=%0t we=%h addr=%h wdata=%h rdata=%h", $time, we_o, addr_o, wrdata_o, rddata_i);
                checks++;
                if (exp_bus_q.size() == 0) begin
                    errors++;
                    $display("FAIL bus_unexpected: got we=%h addr=%h data=%h expected none", we_o, addr_o, wrdata_o);
                end else begin
                    mon_e = exp_bus_q.pop_front();
                    if (we_o !== mon_e.we || addr_o !== mon_e.addr ||
                        wrdata_o !== ((mon_e.we == 4'hF) ? mon_e.data : 32'd0)) begin
                        errors++;
                        $display("FAIL bus_access: got we=%h addr=%h data=%h expected we=%h addr=%h data=%h",
                                 we_o, addr_o, wrdata_o, mon_e.we, mon_e.addr, mon_e.data);
                    end
                end
                if (y_valid_o) check("bus_while_y_valid", 32'(y_valid_o), 32'd0);
                if (we_o == 4'hF && addr_o == L_ADDR) l_writes++;
            end else if (we_o != 4'h0 || addr_o != 8'h0 || wrdata_o != 32'h0) begin
                check("bus_idle_zero", {we_o, addr_o, 20'd0} | wrdata_o, 32'd0);
            end
            if (done_o) done_cnt++;
        end
    end

    // Y monitor: each handshake pops the expected word.
    always @(negedge clk) begin
        if (rst_n && y_valid_o && y_ready_i) begin
            $display("y t=%0t data=%h", $time, y_data_o);
            if (exp_y_q.size() == 0) begin
                check("y_unexpected", y_data_o, 32'hFFFF_FFFF);
            end else begin
                mon_y = exp_y_q.pop_front();
                check("y_data", y_data_o, mon_y);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_bus(input logic [3:0] we, input logic [7:0] a, input logic [31:0] d);
        bus_t e;
        e.we = we; e.addr = a; e.data = d;
        exp_bus_q.push_back(e);
    endtask

    task automatic push_prefix(input logic [31:0] l, input logic [31:0] xbase);
        push_bus(4'hF, L_ADDR, l);
        push_bus(4'hF, PREP_ADDR, 32'd0);
        for (int i = 0; i < 32; i++) push_bus(4'hF, 8'(i * 4), xbase + 32'(i));
        push_bus(4'hF, START_ADDR, 32'd0);
    endtask

    task automatic push_polls(input int n);
        for (int i = 0; i < n; i++) push_bus(4'h0, RDY_ACTIVE_ADDR, 32'd0);
    endtask

    task automatic push_y();
        logic [7:0] a;
        for (int k = 0; k < 16; k++) begin
            a = 8'(8'h80 + k * 4);
            push_bus(4'h0, a, 32'd0);
            exp_y_q.push_back(32'hC0DE_0000 | {24'd0, a});
        end
    endtask

    task automatic start_job(input logic [31:0] l, input int polls);
        rdy_en    = (polls > 0);
        rdy_after = polls;
        poll_base = poll_seen;
        go_i = 1'b1; l_i = l;
        tick();
        go_i = 1'b0; l_i = 32'h0000_0055;
        check("busy_after_go", 32'(busy_o), 32'd1);
        check("err_clear_on_go", 32'(err_o), 32'd0);
    endtask

    task automatic drive_x(input logic [31:0] xbase, input int stall_word, input bit go_busy);
        int n;
        for (int i = 0; i < 32; i++) begin
            if (go_busy && i == 10) begin
                go_i = 1'b1; l_i = 32'h0000_0055;
                tick();
                go_i = 1'b0;
            end
            if (i == stall_word) begin
                x_valid_i = 1'b0;
                repeat (5) tick();
            end
            x_valid_i = 1'b1;
            x_data_i  = xbase + 32'(i);
            n = 0;
            while (!x_ready_o && n < 200) begin tick(); n++; end
            if (n >= 200) check("x_ready_timeout", 32'(n), 32'd0);
            tick();
        end
        // Left asserted with junk: must never be consumed outside WR_X.
        x_data_i = 32'hDEAD_BEEF;
    endtask

    task automatic consume_y(input int bp_word);
        int n;
        logic [31:0] hold;
        y_ready_i = 1'b1;
        for (int k = 0; k < 16; k++) begin
            n = 0;
            while (!y_valid_o && n < 3000) begin tick(); n++; end
            if (n >= 3000) begin
                check("y_valid_timeout", 32'(k), 32'hFFFF_FFFF);
                return;
            end
            if (k == bp_word) begin
                y_ready_i = 1'b0;
                hold = y_data_o;
                repeat (8) begin
                    tick();
                    check("y_hold_data", y_data_o, hold);
                    check("y_hold_valid", 32'(y_valid_o), 32'd1);
                end
                y_ready_i = 1'b1;
            end
            tick();
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_o && n < 3000) begin tick(); n++; end
        check("idle_reached", 32'(busy_o), 32'd0);
    endtask

    task automatic full_job(input logic [31:0] l, input logic [31:0] xbase, input int stall,
                            input int bp, input int polls, input bit go_busy);
        int d0 = done_cnt;
        int l0 = l_writes;
        push_prefix(l, xbase);
        push_polls(polls);
        push_y();
        start_job(l, polls);
        fork
            drive_x(xbase, stall, go_busy);
            consume_y(bp);
        join
        x_valid_i = 1'b0;
        wait_idle();
        check("bus_queue_empty", 32'(exp_bus_q.size()), 32'd0);
        check("y_queue_empty", 32'(exp_y_q.size()), 32'd0);
        check("done_pulses", 32'(done_cnt - d0), 32'd1);
        check("l_write_count", 32'(l_writes - l0), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_en"}, 32'(en_o), 32'd0);
        check({tag, "_we"}, 32'(we_o), 32'd0);
        check({tag, "_addr"}, 32'(addr_o), 32'd0);
        check({tag, "_wrdata"}, wrdata_o, 32'd0);
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
        check({tag, "_done"}, 32'(done_o), 32'd0);
        check({tag, "_err"}, 32'(err_o), 32'd0);
        check({tag, "_x_ready"}, 32'(x_ready_o), 32'd0);
        check({tag, "_y_valid"}, 32'(y_valid_o), 32'd0);
        check({tag, "_y_data"}, y_data_o, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int d0;
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset");
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Full job: L=0x100, X data = index, rdy on 10th poll, no backpressure.
        full_job(32'h0000_0100, 32'h0, -1, -1, 10, 1'b0);
        // X stall before word 7, Y backpressure on word 3, ignored go during WR_X.
        full_job(32'h0000_02A5, 32'h0002_0000, 7, 3, 3, 1'b1);

        // Asynchronous reset while polling (slave never ready).
        d0 = done_cnt;
        push_prefix(32'h0000_0033, 32'h0003_0000);
        push_polls(5);
        start_job(32'h0000_0033, 0);
        drive_x(32'h0003_0000, -1, 1'b0);
        n = 0;
        while ((poll_seen - poll_base) < 5 && n < 2000) begin tick(); n++; end
        check("rst_poll_reached", 32'(poll_seen - poll_base), 32'd5);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        x_valid_i = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        check("rst_bus_queue_empty", 32'(exp_bus_q.size()), 32'd0);
        check("rst_no_done", 32'(done_cnt - d0), 32'd0);
        tick();
        // Next job after reset starts from the L write; rdy on first poll.
        full_job(32'h0000_1234, 32'h0004_0000, -1, -1, 1, 1'b0);

`ifdef BASH_MASTER_TIMEOUT_EN
        // Timeout: 16 poll reads then back to idle with err_o set, no done.
        d0 = done_cnt;
        push_prefix(32'h0000_0077, 32'h0007_0000);
        push_polls(16);
        start_job(32'h0000_0077, 0);
        drive_x(32'h0007_0000, -1, 1'b0);
        x_valid_i = 1'b0;
        wait_idle();
        repeat (3) tick();
        check("timeout_err", 32'(err_o), 32'd1);
        check("timeout_no_done", 32'(done_cnt - d0), 32'd0);
        check("timeout_bus_queue_empty", 32'(exp_bus_q.size()), 32'd0);
        full_job(32'h0000_0088, 32'h0008_0000, -1, -1, 2, 1'b0);
`else
        check("err_tied_low", 32'(err_o), 32'd0);
`endif

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
